i2s_dac_tx: RTL
===============

Name: i2s_dac_tx

Overview:
- Parametrised serial-audio DAC transmitter.
- Generates BCLK and DACLRC itself (codec slave), with selectable I2S or left-justified framing and configurable sample and slot widths.
- Accepts stereo sample pairs via a valid/ready handshake into a one-frame holding buffer; flags an underrun when the buffer is empty at a frame start.
- Sits between the sound source and the codec pins; drives the codec's bclk/daclrc/dacdat inputs.

Parameters:
- SAMPLE_W, 24: bits per channel sample, 8..32.
- SLOT_W, 32: BCLK periods per channel slot, SAMPLE_W..64.
- BCLK_DIV, 8: sys_clk cycles per BCLK period; even, >= 2.
- MODE, 0: 0 = I2S (MSB one BCLK after the DACLRC edge); 1 = left-justified (MSB on the DACLRC edge).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = serialise; 0 = idle the serial outputs.
- s_valid  in  1  source has a sample pair.
- s_ready  out  1  holding buffer empty.
- s_left  in  SAMPLE_W  left sample, two's complement.
- s_right  in  SAMPLE_W  right sample, two's complement.
- bclk  out  1  bit clock, registered.
- daclrc  out  1  0 = left slot, 1 = right slot; registered.
- dacdat  out  1  serial data, MSB first; registered.
- underrun  out  1  one-cycle pulse when a frame starts with an empty buffer.

Behaviour:
- Reset values (async, sys_rst_n low):
  - bclk, daclrc, dacdat, underrun = 0; s_ready = 1.
  - Divider d = 0; bit counter b = 2*SLOT_W-1; hold buffer empty; frame register = 0.
- Divider:
  - While enable = 1, d counts 0..BCLK_DIV-1 and wraps.
  - bclk register = 1 when d >= BCLK_DIV/2, else 0.
  - A "fall event" is the cycle in which d wraps BCLK_DIV-1 -> 0. bclk goes low on that edge.
- Fall event actions:
  - b increments modulo 2*SLOT_W.
  - daclrc <= (new b >= SLOT_W).
  - dacdat <= next serial bit.
  - Outputs change only on fall events, so the codec samples on the BCLK rising edge.
- Frame start (fall event with new b = 0):
  - Hold buffer full: frame register <= {s_left, s_right}, each zero-padded on the LSB side to SLOT_W bits; buffer becomes empty.
  - Hold buffer empty: frame register <= all zeros; underrun = 1 for exactly that cycle.
- Serial bit selection:
  - MODE 1: dacdat = frame bit at position b, MSB first (left slot then right slot).
  - MODE 0: dacdat = the MODE 1 stream delayed by one BCLK period, wrapping across frames. Slot position 0 therefore carries the last bit of the preceding slot: 0 when SLOT_W > SAMPLE_W, the previous sample's LSB otherwise.
- Handshake:
  - s_ready = hold buffer empty.
  - Transfer when s_valid && s_ready; hold <= {s_left, s_right}, so s_ready = 0 the next cycle.
  - A transfer coinciding with a frame start does not feed that frame: the frame takes zeros plus underrun, and the new pair waits for the next frame.
  - s_left/s_right need only be stable in the transfer cycle.
- Latency: a pair accepted while the buffer is empty appears at the next frame start. Its MSB is on dacdat at that fall event (MODE 1) or one BCLK later (MODE 0).
- enable = 0:
  - Synchronous idle on the next edge: d = 0, b = 2*SLOT_W-1, bclk/daclrc/dacdat = 0.
  - Hold buffer and handshake keep operating; no underrun pulses.
- enable rising: first fall event occurs BCLK_DIV cycles later and is a frame start. Partial frames are never resumed.
- Reset mid-frame: everything returns to reset values immediately; the buffered pair is discarded.
- Frame length: 2*SLOT_W*BCLK_DIV sys_clk cycles.

Optional Feature:
- I2S_DAC_MCLK_EN defined:
  - Adds parameter MCLK_DIV (default 2; even, >= 2).
  - Adds output port mclk (1 bit): the master clock for the codec XCK pin.
  - mclk toggles every MCLK_DIV/2 sys_clk cycles, free-running, independent of enable; reset value 0.
- I2S_DAC_MCLK_EN undefined: no mclk port, no MCLK_DIV parameter, no related logic.

Test Plan:
- MODE=1, SAMPLE_W=24, SLOT_W=32, BCLK_DIV=4; push left=0xA5A5A5, right=0x123456 before enable -> first frame: slot 0 bits = 0xA5A5A5 followed by 8 zeros; slot 1 bits = 0x123456 followed by 8 zeros; daclrc rises at b=32; frame = 256 cycles; no underrun.
- Same stimulus with MODE=0 -> same bit stream delayed by one BCLK: slot 0 position 0 = 0, MSB 1 at position 1; daclrc edges unchanged.
- enable=1 with no sample pushed -> underrun pulses once per frame (every 256 cycles, 1 cycle wide); dacdat constant 0.
- s_valid asserted in the exact cycle of a frame start with the buffer empty -> underrun=1 that cycle, frame all zeros, pair serialised in the following frame, s_ready=0 in between.
- Continuous s_valid=1 with incrementing samples over 3 frames -> exactly one transfer per frame, each sample serialised once in order, no underrun after the first frame.
- Assert sys_rst_n=0 mid right slot -> all outputs 0 and s_ready=1 asynchronously; after release the next frame starts with underrun.

Source files
------------

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_dac_tx
//  Purpose  : Serial-audio DAC transmitter (codec slave). Generates BCLK and
//             DACLRC, serialises stereo pairs MSB first in I2S (MODE=0) or
//             left-justified (MODE=1) framing, one-frame holding buffer with
//             valid/ready input and an underrun pulse on empty frame start.
//  Option   : define I2S_DAC_MCLK_EN to add a free-running mclk output
//             (divider MCLK_DIV).
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_dac_tx #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8,
`ifdef I2S_DAC_MCLK_EN
    parameter int MCLK_DIV = 2,
`endif
    parameter int MODE     = 0
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
`ifdef I2S_DAC_MCLK_EN
    output logic                mclk,
`endif
    output logic                bclk,
    output logic                daclrc,
    output logic                dacdat,
    output logic                underrun
);

    localparam int c_frame_w = 2 * SLOT_W;
    localparam int c_dw      = $clog2(BCLK_DIV);
    localparam int c_bw      = $clog2(c_frame_w);

    localparam logic [c_dw-1:0] c_d_last = c_dw'(BCLK_DIV - 1);
    localparam logic [c_dw-1:0] c_d_half = c_dw'(BCLK_DIV / 2);
    localparam logic [c_bw-1:0] c_b_last = c_bw'(c_frame_w - 1);
    localparam logic [c_bw-1:0] c_b_slot = c_bw'(SLOT_W);

    logic [c_dw-1:0]       d_q, d_d;
    logic [c_bw-1:0]       b_q, b_d;
    logic                  bclk_q, bclk_d;
    logic                  daclrc_q, daclrc_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underrun_q, underrun_d;
    logic                  prev_bit_q, prev_bit_d;
    logic                  hold_full_q, hold_full_d;
    logic [2*SAMPLE_W-1:0] hold_q, hold_d;
    logic [c_frame_w-1:0]  frame_q, frame_d;

    logic                  fall;
    logic                  frame_start;
    logic                  xfer;
    logic [c_bw-1:0]       b_inc;
    logic [c_bw-1:0]       bit_idx;
    logic [c_frame_w-1:0]  pad_frame;
    logic                  lj_bit;

    // Next-state logic: divider, bit counter, frame loading, buffer, serial bit
    always_comb begin
        fall        = enable && (d_q == c_d_last);
        b_inc       = (b_q == c_b_last) ? '0 : b_q + 1'b1;
        frame_start = fall && (b_inc == '0);
        xfer        = s_valid && !hold_full_q;

        // Each sample sits MSB-aligned in its slot, zero padding below it
        pad_frame = '0;
        pad_frame[c_frame_w-1 -: SAMPLE_W] = hold_q[2*SAMPLE_W-1 -: SAMPLE_W];
        pad_frame[SLOT_W-1 -: SAMPLE_W]    = hold_q[SAMPLE_W-1:0];

        // A pair accepted on a frame-start edge waits for the next frame
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (xfer) begin
            hold_d      = {s_left, s_right};
            hold_full_d = 1'b1;
        end else if (frame_start && hold_full_q) begin
            hold_full_d = 1'b0;
        end

        frame_d = frame_q;
        if (frame_start) begin
            frame_d = hold_full_q ? pad_frame : '0;
        end

        // Left-justified bit for the new position; the I2S stream is this
        // stream delayed by one BCLK, carried through prev_bit
        bit_idx = c_b_last - b_inc;
        lj_bit  = frame_d[bit_idx];

        if (!enable) begin
            d_d        = '0;
            b_d        = c_b_last;
            bclk_d     = 1'b0;
            daclrc_d   = 1'b0;
            dacdat_d   = 1'b0;
            prev_bit_d = 1'b0;
            underrun_d = 1'b0;
        end else begin
            d_d        = fall ? '0 : d_q + 1'b1;
            bclk_d     = (d_d >= c_d_half);
            b_d        = b_q;
            daclrc_d   = daclrc_q;
            dacdat_d   = dacdat_q;
            prev_bit_d = prev_bit_q;
            underrun_d = frame_start && !hold_full_q;
            if (fall) begin
                b_d        = b_inc;
                daclrc_d   = (b_inc >= c_b_slot);
                prev_bit_d = lj_bit;
                dacdat_d   = (MODE == 1) ? lj_bit : prev_bit_q;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d_q         <= '0;
            b_q         <= c_b_last;
            bclk_q      <= 1'b0;
            daclrc_q    <= 1'b0;
            dacdat_q    <= 1'b0;
            underrun_q  <= 1'b0;
            prev_bit_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            frame_q     <= '0;
        end else begin
            d_q         <= d_d;
            b_q         <= b_d;
            bclk_q      <= bclk_d;
            daclrc_q    <= daclrc_d;
            dacdat_q    <= dacdat_d;
            underrun_q  <= underrun_d;
            prev_bit_q  <= prev_bit_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            frame_q     <= frame_d;
        end
    end

    assign s_ready  = !hold_full_q;
    assign bclk     = bclk_q;
    assign daclrc   = daclrc_q;
    assign dacdat   = dacdat_q;
    assign underrun = underrun_q;

`ifdef I2S_DAC_MCLK_EN
    localparam int c_mw = (MCLK_DIV > 2) ? $clog2(MCLK_DIV / 2) : 1;
    localparam logic [c_mw-1:0] c_m_last = c_mw'(MCLK_DIV / 2 - 1);

    logic [c_mw-1:0] mcnt_q, mcnt_d;
    logic            mclk_q, mclk_d;

    // Free-running master clock, toggles every MCLK_DIV/2 cycles
    always_comb begin
        mcnt_d = mcnt_q + 1'b1;
        mclk_d = mclk_q;
        if (mcnt_q == c_m_last) begin
            mcnt_d = '0;
            mclk_d = ~mclk_q;
        end
    end

    // Master clock registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mcnt_q <= '0;
            mclk_q <= 1'b0;
        end else begin
            mcnt_q <= mcnt_d;
            mclk_q <= mclk_d;
        end
    end

    assign mclk = mclk_q;
`endif

endmodule
`default_nettype wire
